pc_fetch_unit: RTL and testbench

- Instruction-fetch front end of the MIPS CPU.
- Holds the program counter (PC) and drives it into the PC+4 adder's a input; the adder's b input is tied to 32'd4 at the top level.
- Takes the adder result back as the sequential next PC, and accepts branch/jump redirects.
- Issues one instruction-memory request at a time over a valid/ready handshake and presents the fetched instruction to decode through a registered valid/ready output.

---
 rtl/pc_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end of the MIPS CPU.
//
// Holds the program counter and sends it to an external PC+4 adder. The
// adder result comes back as the sequential next PC. Branch/jump redirects
// are also accepted here. Only one instruction-memory request is in flight
// at a time. The fetched word goes to decode through a registered
// valid/ready stage.
//
// Handshake rule, for every valid/ready pair on this block: a transfer
// happens on a rising clk edge where valid and ready are both 1. A valid
// output stays asserted until it is accepted or flushed by a redirect, and
// its payload holds stable while it waits.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   pc_o                current PC (PC+4 adder input a)
//   pcplus4_i           PC+4 adder output y
//   redirect_i/_pc_i    one-cycle taken branch/jump pulse and its target
//   imem_req_*          fetch request (valid/ready) and address
//   imem_resp_*         fetch response (one valid cycle per accepted request)
//   if_valid_o/_instr_o/_pc_o, if_ready_i   instruction output to decode
//   dbg_state_o         FSM state (0 = REQ, 1 = WAIT, 2 = OUT)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_o,
  input  logic [31:0] pcplus4_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_discard;
  logic        r_active;   // low from reset until the first clock edge after release
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;

  logic        w_req_valid;
  logic        w_req_hs;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  // The request is held off until the first edge after reset release, so
  // it stays low for the whole time reset is asserted.
  assign w_req_valid   = r_active && (r_state == S_REQ);
  assign w_req_hs      = w_req_valid && imem_req_ready_i;
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_unused      = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_fetch_pc <= 32'd0;
      r_discard  <= 1'b0;
      r_active   <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
    end else begin
      r_active <= 1'b1;
      if (redirect_i) begin
        // A redirect beats every other event in this cycle. pcplus4_i is
        // never loaded, and a pending decode output is flushed.
        r_pc       <= w_redirect_pc;
        r_if_valid <= 1'b0;
        case (r_state)
          S_REQ: begin
            // The request is still issued if memory takes it this cycle.
            // Its response belongs to the old path, so it is marked for
            // dropping.
            if (w_req_hs) begin
              r_fetch_pc <= r_pc;
              r_discard  <= 1'b1;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid_i) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_discard <= 1'b1;
            end
          end
          S_OUT:   r_state <= S_REQ;
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_req_hs) begin
              r_fetch_pc <= r_pc;
              r_pc       <= pcplus4_i;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid_i) begin
              if (r_discard) begin
                r_discard <= 1'b0;
                r_state   <= S_REQ;
              end else begin
                r_if_instr <= imem_resp_data_i;
                r_if_pc    <= r_fetch_pc;
                r_if_valid <= 1'b1;
                r_state    <= S_OUT;
              end
            end
          end
          S_OUT: begin
            if (if_ready_i) begin
              r_if_valid <= 1'b0;
              r_state    <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

  assign pc_o             = r_pc;
  assign imem_addr_o      = r_pc;
  assign imem_req_valid_o = w_req_valid;
  assign if_valid_o       = r_if_valid;
  assign if_instr_o       = r_if_instr;
  assign if_pc_o          = r_if_pc;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. It contains a randomised instruction-memory
// model and an event log. A reference model replays the log with
// address-stream rules: +4 per fetch, restart at the masked target on a
// redirect.
module tb_pc_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RESET_PC = 0) ----------------
  logic [31:0] pc_o, pcplus4, redirect_pc, imem_addr, imem_resp_data, if_instr, if_pc;
  logic        redirect, imem_req_valid, imem_req_ready, imem_resp_valid, if_valid, if_ready;
  logic [1:0]  dbg_state;

  assign pcplus4 = pc_o + 32'd4;  // top-level PC+4 adder

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .pc_o(pc_o), .pcplus4_i(pcplus4),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(imem_req_valid), .imem_req_ready_i(imem_req_ready),
    .imem_addr_o(imem_addr), .imem_resp_valid_i(imem_resp_valid),
    .imem_resp_data_i(imem_resp_data), .if_valid_o(if_valid),
    .if_instr_o(if_instr), .if_pc_o(if_pc), .if_ready_i(if_ready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- wrap DUT (RESET_PC = 0xFFFF_FFFC) ----------------
  logic [31:0] w_pc, w_pcplus4, w_addr, w_resp_data, w_if_instr, w_if_pc;
  logic        w_req_valid, w_ready, w_resp_valid, w_if_valid, w_if_ready, w_redirect;
  logic [1:0]  w_state;

  assign w_pcplus4 = w_pc + 32'd4;

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .pc_o(w_pc), .pcplus4_i(w_pcplus4),
    .redirect_i(w_redirect), .redirect_pc_i(32'h0000_0000),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_ready),
    .imem_addr_o(w_addr), .imem_resp_valid_i(w_resp_valid),
    .imem_resp_data_i(w_resp_data), .if_valid_o(w_if_valid),
    .if_instr_o(w_if_instr), .if_pc_o(w_if_pc), .if_ready_i(w_if_ready),
    .dbg_state_o(w_state)
  );

  // ---------------- bench state ----------------
  int tests_run = 0;
  int tests_failed = 0;

  int k_ready_pct, k_dec_pct, k_lat_min, k_lat_max;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          ovr_once;
  logic [31:0] ovr_data;

  // Event log: kind 0 = request accepted (a = addr),
  // kind 1 = instruction taken by decode (a = pc, b = instr),
  // kind 2 = redirect (a = raw target).
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;
  ev_t ev_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  // Index of the first event of the given kind after the first redirect, or -1.
  function automatic int first_after_red(input int kind);
    bit seen = 1'b0;
    for (int i = 0; i < ev_q.size(); i++) begin
      if (ev_q[i].kind == 2) seen = 1'b1;
      else if (seen && ev_q[i].kind == kind) return i;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  // This task is called at a negedge. It drives inputs for the coming
  // posedge, logs what will happen at that edge, and returns at the next
  // negedge.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    ev_t e;
    if (mem_pend && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ovr_once ? ovr_data : mem_word(mem_addr);
      ovr_once = 1'b0;
      mem_pend = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_pend) mem_cnt--;
    end
    imem_req_ready = ($urandom_range(99) < k_ready_pct);
    if_ready       = ($urandom_range(99) < k_dec_pct);
    redirect       = redir;
    redirect_pc    = tgt;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      e = '{kind: 0, a: imem_addr, b: 32'd0};
      ev_q.push_back(e);
      mem_pend = 1'b1;
      mem_cnt  = int'($urandom_range(k_lat_max, k_lat_min));
      mem_addr = imem_addr;
    end
    if (if_valid && if_ready && !redir) begin
      e = '{kind: 1, a: if_pc, b: if_instr};
      ev_q.push_back(e);
    end
    if (redir) begin
      e = '{kind: 2, a: tgt, b: 32'd0};
      ev_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; ovr_once = 1'b0;
    ev_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b1;
    #1;
    tests_run++;
    if (pc_o !== 32'd0 || imem_addr !== 32'd0) begin
      tests_failed++; $display("FAIL reset_pc: got pc %h addr %h want 0", pc_o, imem_addr);
    end
    tests_run++;
    if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_if: got v=%b i=%h p=%h want 0", if_valid, if_instr, if_pc);
    end
    @(posedge clk); #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_held_req: got %b want 0", imem_req_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release_req: got %b want 0", imem_req_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_first_edge: got req %b state %0d want 1/0", imem_req_valid, dbg_state);
    end
  endtask

  task automatic test_basic();
    logic [31:0] req_a[$];
    logic [31:0] del_p[$];
    logic [31:0] del_i[$];
    do_reset();
    k_ready_pct = 100; k_dec_pct = 100; k_lat_min = 0; k_lat_max = 0;
    repeat (13) cycle(1'b0, 32'd0);
    foreach (ev_q[i]) begin
      if (ev_q[i].kind == 0) req_a.push_back(ev_q[i].a);
      if (ev_q[i].kind == 1) begin del_p.push_back(ev_q[i].a); del_i.push_back(ev_q[i].b); end
    end
    tests_run++;
    if (req_a.size() < 3 || del_p.size() < 3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d reqs %0d dels want >=3", req_a.size(), del_p.size());
    end else begin
      exp_q = '{32'h0, 32'h4, 32'h8};
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (req_a[i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL basic_addr%0d: got %h want %h", i, req_a[i], exp_q[i]);
        end
        tests_run++;
        if (del_p[i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL basic_if_pc%0d: got %h want %h", i, del_p[i], exp_q[i]);
        end
        tests_run++;
        if (del_i[i] !== mem_word(exp_q[i])) begin
          tests_failed++;
          $display("FAIL basic_instr%0d: got %h want %h", i, del_i[i], mem_word(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cap_i, cap_p;
    bit got = 1'b0;
    do_reset();
    k_ready_pct = 100; k_dec_pct = 0; k_lat_min = 0; k_lat_max = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle(1'b0, 32'd0);
      if (if_valid === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL bp_reach_out: got no if_valid want 1 within 20 cycles");
    end else begin
      cap_i = if_instr; cap_p = if_pc;
      for (int n = 0; n < 5; n++) begin
        cycle(1'b0, 32'd0);
        tests_run++;
        if (if_valid !== 1'b1 || if_instr !== cap_i || if_pc !== cap_p || imem_req_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_hold%0d: got v=%b i=%h p=%h req=%b want 1/%h/%h/0",
                   n, if_valid, if_instr, if_pc, imem_req_valid, cap_i, cap_p);
        end
      end
      k_dec_pct = 100;
      cycle(1'b0, 32'd0);
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_addr !== cap_p + 32'd4 || if_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_resume: got req=%b addr=%h v=%b want 1/%h/0",
                 imem_req_valid, imem_addr, if_valid, cap_p + 32'd4);
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit got = 1'b0;
    int idx;
    do_reset();
    k_ready_pct = 100; k_dec_pct = 100; k_lat_min = 2; k_lat_max = 2;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle(1'b0, 32'd0);
      if (dbg_state === 2'd1) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL rw_reach_wait: got no WAIT want WAIT within 20 cycles");
    end else begin
      ovr_once = 1'b1; ovr_data = 32'hDEAD_BEEF;
      cycle(1'b1, 32'h0000_0100);
      repeat (15) cycle(1'b0, 32'd0);
      foreach (ev_q[i]) begin
        if (ev_q[i].kind == 1) begin
          tests_run++;
          if (ev_q[i].b === 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL rw_dropped: got instr %h delivered want dropped", ev_q[i].b);
          end
        end
      end
      idx = first_after_red(0);
      tests_run++;
      if (idx < 0 || ev_q[idx].a !== 32'h100) begin
        tests_failed++;
        $display("FAIL rw_next_addr: got %h want 00000100", (idx < 0) ? 32'hx : ev_q[idx].a);
      end
      idx = first_after_red(1);
      tests_run++;
      if (idx < 0 || ev_q[idx].a !== 32'h100 || ev_q[idx].b !== mem_word(32'h100)) begin
        tests_failed++;
        $display("FAIL rw_next_if: got pc %h instr %h want 00000100 %h",
                 (idx < 0) ? 32'hx : ev_q[idx].a, (idx < 0) ? 32'hx : ev_q[idx].b, mem_word(32'h100));
      end
    end
  endtask

  task automatic test_redirect_handshake();
    bit got = 1'b0;
    int idx;
    do_reset();
    k_ready_pct = 100; k_dec_pct = 100; k_lat_min = 0; k_lat_max = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (dbg_state === 2'd0 && imem_req_valid === 1'b1 && imem_addr === 32'h10) got = 1'b1;
      else cycle(1'b0, 32'd0);
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL rh_reach_req10: got addr %h want 00000010 in REQ", imem_addr);
    end else begin
      cycle(1'b1, 32'h0000_0203);
      repeat (12) cycle(1'b0, 32'd0);
      idx = first_after_red(0);
      tests_run++;
      if (idx < 0 || ev_q[idx].a !== 32'h200) begin
        tests_failed++;
        $display("FAIL rh_next_addr: got %h want 00000200", (idx < 0) ? 32'hx : ev_q[idx].a);
      end
      idx = first_after_red(1);
      tests_run++;
      if (idx < 0 || ev_q[idx].a !== 32'h200) begin
        tests_failed++;
        $display("FAIL rh_next_if: got %h want 00000200", (idx < 0) ? 32'hx : ev_q[idx].a);
      end
      foreach (ev_q[i]) begin
        if (ev_q[i].kind == 1) begin
          tests_run++;
          if (ev_q[i].a === 32'h10 || ev_q[i].a === 32'h14) begin
            tests_failed++; $display("FAIL rh_stale: got pc %h delivered want dropped", ev_q[i].a);
          end
        end
      end
    end
  endtask

  task automatic test_redirect_out();
    bit got = 1'b0;
    int idx;
    logic [31:0] cap_p;
    do_reset();
    k_ready_pct = 100; k_dec_pct = 0; k_lat_min = 0; k_lat_max = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle(1'b0, 32'd0);
      if (if_valid === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL ro_reach_out: got no if_valid want 1 within 20 cycles");
    end else begin
      cap_p = if_pc;
      k_dec_pct = 100;
      cycle(1'b1, 32'h0000_0300);
      tests_run++;
      if (if_valid !== 1'b0) begin
        tests_failed++; $display("FAIL ro_flush: got if_valid %b want 0", if_valid);
      end
      repeat (12) cycle(1'b0, 32'd0);
      foreach (ev_q[i]) begin
        if (ev_q[i].kind == 1) begin
          tests_run++;
          if (ev_q[i].a === cap_p) begin
            tests_failed++; $display("FAIL ro_accepted: got pc %h accepted want flushed", cap_p);
          end
        end
      end
      idx = first_after_red(0);
      tests_run++;
      if (idx < 0 || ev_q[idx].a !== 32'h300) begin
        tests_failed++;
        $display("FAIL ro_next_addr: got %h want 00000300", (idx < 0) ? 32'hx : ev_q[idx].a);
      end
      idx = first_after_red(1);
      tests_run++;
      if (idx < 0 || ev_q[idx].a !== 32'h300) begin
        tests_failed++;
        $display("FAIL ro_next_if: got %h want 00000300", (idx < 0) ? 32'hx : ev_q[idx].a);
      end
    end
  endtask

  task automatic test_async_reset();
    bit got = 1'b0;
    do_reset();
    k_ready_pct = 100; k_dec_pct = 100; k_lat_min = 0; k_lat_max = 0;
    repeat (8) cycle(1'b0, 32'd0);
    k_lat_min = 3; k_lat_max = 3;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle(1'b0, 32'd0);
      if (dbg_state === 2'd1) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL ar_reach_wait: got no WAIT want WAIT within 20 cycles");
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (pc_o !== 32'd0 || imem_addr !== 32'd0 || imem_req_valid !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL ar_pc_req: got pc %h addr %h req %b st %0d want 0/0/0/0",
               pc_o, imem_addr, imem_req_valid, dbg_state);
    end
    tests_run++;
    if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL ar_if: got v=%b i=%h p=%h want 0", if_valid, if_instr, if_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_pend = 1'b0;
    imem_req_ready = 1'b0; if_ready = 1'b1; redirect = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL ar_stale_resp: got v=%b st=%0d want 0/0", if_valid, dbg_state);
    end
    imem_resp_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] req_a[$];
    logic [31:0] del_p[$];
    w_ready = 1'b1; w_if_ready = 1'b1; w_resp_valid = 1'b1;
    w_resp_data = 32'hCAFE_0001; w_redirect = 1'b0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (w_pc !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_reset_pc: got %h want fffffffc", w_pc);
    end
    do_reset();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (w_req_valid === 1'b1) req_a.push_back(w_addr);
      if (w_if_valid === 1'b1) del_p.push_back(w_if_pc);
    end
    tests_run++;
    if (req_a.size() < 2 || req_a[0] !== 32'hFFFF_FFFC || req_a[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %0d reqs first %h second %h want fffffffc 00000000",
               req_a.size(), (req_a.size() > 0) ? req_a[0] : 32'hx, (req_a.size() > 1) ? req_a[1] : 32'hx);
    end
    tests_run++;
    if (del_p.size() < 2 || del_p[0] !== 32'hFFFF_FFFC || del_p[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_if_pc: got %0d dels first %h second %h want fffffffc 00000000",
               del_p.size(), (del_p.size() > 0) ? del_p[0] : 32'hx, (del_p.size() > 1) ? del_p[1] : 32'hx);
    end
    w_ready = 1'b0; w_resp_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_req, exp_dec;
    int ndel = 0;
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      k_ready_pct = int'($urandom_range(100, 30));
      k_dec_pct   = int'($urandom_range(100, 30));
      k_lat_min   = 0;
      k_lat_max   = int'($urandom_range(3, 0));
      for (int n = 0; n < 100; n++) begin
        if ($urandom_range(99) < 4) cycle(1'b1, $urandom);
        else cycle(1'b0, 32'd0);
      end
    end
    // Reference: requests and deliveries each form a +4 address stream
    // that restarts at the word-aligned target after every redirect.
    exp_req = 32'h0;
    exp_dec = 32'h0;
    foreach (ev_q[i]) begin
      case (ev_q[i].kind)
        0: begin
          tests_run++;
          if (ev_q[i].a !== exp_req) begin
            tests_failed++; $display("FAIL rnd_addr ev%0d: got %h want %h", i, ev_q[i].a, exp_req);
          end
          exp_req = exp_req + 32'd4;
        end
        1: begin
          ndel++;
          tests_run++;
          if (ev_q[i].a !== exp_dec || ev_q[i].b !== mem_word(exp_dec)) begin
            tests_failed++;
            $display("FAIL rnd_if ev%0d: got pc %h instr %h want %h %h",
                     i, ev_q[i].a, ev_q[i].b, exp_dec, mem_word(exp_dec));
          end
          exp_dec = exp_dec + 32'd4;
        end
        default: begin
          exp_req = {ev_q[i].a[31:2], 2'b00};
          exp_dec = {ev_q[i].a[31:2], 2'b00};
        end
      endcase
    end
    tests_run++;
    if (ndel < 10) begin
      tests_failed++; $display("FAIL rnd_progress: got %0d deliveries want >=10", ndel);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    w_ready = 1'b0; w_if_ready = 1'b0; w_resp_valid = 1'b0;
    w_resp_data = 32'd0; w_redirect = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_handshake();
    test_redirect_out();
    test_async_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
